// File: rtl/mesh_gnrtr.sv
// mesh_gnrtr: terminal-level model of a ROWS x COLUMS mesh. Every edge
// terminal has an ingress and an egress FIFO; a crossbar moves ingress heads
// to the egress FIFO their {row,col} names, or to all others on broadcast.
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   pndng_i_in[i]   terminal i offers a packet
//   data_out_i_in[i] packet offered by terminal i
//   popin[i]        one-cycle pulse: packet of terminal i captured this edge
//   pndng[i]        egress FIFO i non-empty
//   data_out[i]     head of egress FIFO i, zero when empty
//   pop[i]          terminal i consumes the head of egress FIFO i
module mesh_gnrtr #(
    parameter int         ROWS       = 4,
    parameter int         COLUMS     = 4,
    parameter int         pckg_sz    = 40,
    parameter int         fifo_depth = 4,
    parameter logic [7:0] bdcst      = 8'hFF,
    localparam int        NT         = 2 * (ROWS + COLUMS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [0:NT-1]      pndng_i_in,
    input  logic [pckg_sz-1:0] data_out_i_in [0:NT-1],
    output logic [0:NT-1]      popin,
    output logic [0:NT-1]      pndng,
    output logic [pckg_sz-1:0] data_out [0:NT-1],
    input  logic [0:NT-1]      pop
);

    localparam int P  = pckg_sz;
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;
    localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CW = $clog2(fifo_depth + 1);
    localparam logic [CW-1:0] FULL = CW'(fifo_depth);

    // ingress state
    logic [P-1:0]  in_mem_q [0:NT-1][0:fifo_depth-1];
    logic [AW-1:0] in_wp_q  [0:NT-1];
    logic [AW-1:0] in_rp_q  [0:NT-1];
    logic [CW-1:0] in_cnt_q [0:NT-1];
    logic [0:NT-1] popin_q;
    logic [0:NT-1] popin_d;
    // one edge of settling after reset before any capture is offered
    logic          rdy_q;

    // egress state
    logic [P-1:0]  eg_mem_q [0:NT-1][0:fifo_depth-1];
    logic [AW-1:0] eg_wp_q  [0:NT-1];
    logic [AW-1:0] eg_rp_q  [0:NT-1];
    logic [CW-1:0] eg_cnt_q [0:NT-1];

    // arbitration state
    logic [TW-1:0] rr_q [0:NT-1];
    logic [TW-1:0] rr_d [0:NT-1];
    logic [TW-1:0] bc_ptr_q;
    logic [TW-1:0] bc_ptr_d;

    // crossbar signals
    logic [P-1:0]  in_head [0:NT-1];
    logic [TW:0]   rt      [0:NT-1];
    logic [TW-1:0] uc_dst  [0:NT-1];
    logic [TW-1:0] eg_sel  [0:NT-1];
    logic [0:NT-1] in_vld;
    logic [0:NT-1] is_bc;
    logic [0:NT-1] uc_ok;
    logic [0:NT-1] in_pop;
    logic [0:NT-1] eg_space;
    logic [0:NT-1] eg_wr;
    logic [0:NT-1] eg_pop;
    logic          bc_go;
    logic [TW-1:0] bc_src;

    // {valid, terminal id} for a row/column pair on the mesh rim
    function automatic logic [TW:0] route(input logic [3:0] r,
                                          input logic [3:0] c);
        int          ri;
        int          ci;
        logic [TW:0] res;
        ri  = int'(r);
        ci  = int'(c);
        res = '0;
        if (ri == 0 && ci >= 1 && ci <= COLUMS)
            res = {1'b1, TW'(ci - 1)};
        else if (ci == 0 && ri >= 1 && ri <= ROWS)
            res = {1'b1, TW'(COLUMS + ri - 1)};
        else if (ri == ROWS + 1 && ci >= 1 && ci <= COLUMS)
            res = {1'b1, TW'(COLUMS + ROWS + ci - 1)};
        else if (ci == COLUMS + 1 && ri >= 1 && ri <= ROWS)
            res = {1'b1, TW'(2 * COLUMS + ROWS + ri - 1)};
        return res;
    endfunction

    function automatic logic [TW-1:0] tid_inc(input logic [TW-1:0] v);
        return (int'(v) == NT - 1) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] v);
        return (int'(v) == fifo_depth - 1) ? '0 : v + 1'b1;
    endfunction

    function automatic logic [TW-1:0] rot(input logic [TW-1:0] base,
                                          input int k);
        int s;
        s = int'(base) + k;
        if (s >= NT)
            s = s - NT;
        return TW'(s);
    endfunction

    // head decode
    always_comb begin
        for (int i = 0; i < NT; i++) begin
            in_head[i] = in_mem_q[i][in_rp_q[i]];
            in_vld[i]  = (in_cnt_q[i] != '0);
            is_bc[i]   = in_vld[i] && (in_head[i][P-9:P-16] == bdcst);
            rt[i]      = route(in_head[i][P-9:P-12],
                               in_head[i][P-13:P-16]);
            uc_ok[i]   = in_vld[i] && !is_bc[i] && rt[i][TW];
            uc_dst[i]  = rt[i][TW-1:0];
        end
    end

    // ingress handshake: pulse, then at least one idle cycle
    always_comb begin
        for (int i = 0; i < NT; i++) begin
            popin_d[i] = rdy_q && pndng_i_in[i] && !popin_q[i]
                         && (in_cnt_q[i] != FULL);
        end
    end

    // crossbar arbitration
    always_comb begin
        logic [TW-1:0] ix;
        logic [0:NT-1] oh;
        logic          hit;
        ix       = '0;
        oh       = '0;
        hit      = 1'b0;
        in_pop   = '0;
        eg_wr    = '0;
        bc_go    = 1'b0;
        bc_src   = '0;
        bc_ptr_d = bc_ptr_q;
        for (int j = 0; j < NT; j++) begin
            eg_sel[j]   = '0;
            rr_d[j]     = rr_q[j];
            eg_space[j] = (eg_cnt_q[j] != FULL);
            eg_pop[j]   = pop[j] && (eg_cnt_q[j] != '0);
        end

        // one broadcast per cycle, only when every target has room
        for (int k = 0; k < NT; k++) begin
            ix     = rot(bc_ptr_q, k);
            oh     = '0;
            oh[ix] = 1'b1;
            if (!bc_go && is_bc[ix] && (&(eg_space | oh))) begin
                bc_go  = 1'b1;
                bc_src = ix;
            end
        end
        if (bc_go) begin
            in_pop[bc_src] = 1'b1;
            bc_ptr_d       = tid_inc(bc_src);
            for (int j = 0; j < NT; j++) begin
                if (j != int'(bc_src)) begin
                    eg_wr[j]  = 1'b1;
                    eg_sel[j] = bc_src;
                end
            end
        end

        // unroutable heads are discarded
        for (int i = 0; i < NT; i++) begin
            if (in_vld[i] && !is_bc[i] && !uc_ok[i])
                in_pop[i] = 1'b1;
        end

        // per-egress round robin over unicast heads
        for (int j = 0; j < NT; j++) begin
            hit = 1'b0;
            if (!eg_wr[j] && eg_space[j]) begin
                for (int k = 0; k < NT; k++) begin
                    ix = rot(rr_q[j], k);
                    if (!hit && uc_ok[ix] && int'(uc_dst[ix]) == j) begin
                        hit        = 1'b1;
                        eg_wr[j]   = 1'b1;
                        eg_sel[j]  = ix;
                        in_pop[ix] = 1'b1;
                        rr_d[j]    = tid_inc(ix);
                    end
                end
            end
        end
    end

    // FIFO pointers, counters, arbiter pointers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q    <= 1'b0;
            popin_q  <= '0;
            bc_ptr_q <= '0;
            for (int i = 0; i < NT; i++) begin
                in_wp_q[i]  <= '0;
                in_rp_q[i]  <= '0;
                in_cnt_q[i] <= '0;
                eg_wp_q[i]  <= '0;
                eg_rp_q[i]  <= '0;
                eg_cnt_q[i] <= '0;
                rr_q[i]     <= '0;
            end
        end else begin
            rdy_q    <= 1'b1;
            popin_q  <= popin_d;
            bc_ptr_q <= bc_ptr_d;
            for (int i = 0; i < NT; i++) begin
                if (popin_q[i])
                    in_wp_q[i] <= ptr_inc(in_wp_q[i]);
                if (in_pop[i])
                    in_rp_q[i] <= ptr_inc(in_rp_q[i]);
                in_cnt_q[i] <= in_cnt_q[i] + CW'(popin_q[i])
                               - CW'(in_pop[i]);
                if (eg_wr[i])
                    eg_wp_q[i] <= ptr_inc(eg_wp_q[i]);
                if (eg_pop[i])
                    eg_rp_q[i] <= ptr_inc(eg_rp_q[i]);
                eg_cnt_q[i] <= eg_cnt_q[i] + CW'(eg_wr[i])
                               - CW'(eg_pop[i]);
                rr_q[i] <= rr_d[i];
            end
        end
    end

    // FIFO storage; contents are only visible through valid counts
    always_ff @(posedge clk) begin
        for (int i = 0; i < NT; i++) begin
            if (popin_q[i])
                in_mem_q[i][in_wp_q[i]] <= data_out_i_in[i];
            if (eg_wr[i])
                eg_mem_q[i][eg_wp_q[i]] <= in_head[eg_sel[i]];
        end
    end

    assign popin = popin_q;

    always_comb begin
        for (int j = 0; j < NT; j++) begin
            pndng[j]    = (eg_cnt_q[j] != '0);
            data_out[j] = pndng[j] ? eg_mem_q[j][eg_rp_q[j]] : '0;
        end
    end

endmodule

// File: tb/tb_mesh_gnrtr.sv
// tb_mesh_gnrtr: directed checks of mesh_gnrtr (unicast, broadcast,
// contention, backpressure, drop, reset) with hand-computed expectations.
module tb_mesh_gnrtr;

    localparam int P  = 40;
    localparam int NT = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [0:NT-1] pndng_i_in;
    logic [P-1:0]  data_out_i_in [0:NT-1];
    logic [0:NT-1] popin;
    logic [0:NT-1] pndng;
    logic [P-1:0]  data_out [0:NT-1];
    logic [0:NT-1] pop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mesh_gnrtr dut (
        .clk           (clk),
        .reset         (reset),
        .pndng_i_in    (pndng_i_in),
        .data_out_i_in (data_out_i_in),
        .popin         (popin),
        .pndng         (pndng),
        .data_out      (data_out),
        .pop           (pop)
    );

    function automatic logic [P-1:0] pk(input logic [7:0] nj,
                                        input logic [3:0] r,
                                        input logic [3:0] c,
                                        input logic m,
                                        input logic [22:0] pl);
        return {nj, r, c, m, pl};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // offer p on terminal i, wait for the capture edge, then withdraw
    task automatic send(input int i, input logic [P-1:0] p,
                        input string tag);
        int n;
        n = 0;
        pndng_i_in[i]    = 1'b1;
        data_out_i_in[i] = p;
        do begin
            @(negedge clk);
            n++;
        end while (!popin[i] && n < 8);
        chk({tag, "_popin"}, popin[i], 1);
        chk({tag, "_popin_delay"}, (n <= 2), 1);
        @(posedge clk);
        @(negedge clk);
        pndng_i_in[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [P-1:0]  pa, pb, pi, pr;
        logic [P-1:0]  ex [0:2];
        logic [0:NT-1] e;
        int            sent, got;
        logic          acc;

        pndng_i_in = '0;
        pop        = '0;
        for (int i = 0; i < NT; i++)
            data_out_i_in[i] = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_popin", popin, 0);
        chk("rst_pndng", pndng, 0);
        chk("rst_data9", data_out[9], 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // unicast 0 -> id 9 (row 5, col 2)
        pa = pk(8'hA5, 4'd5, 4'd2, 1'b0, 23'h123);
        send(0, pa, "t1");
        chk("t1_single_pulse", popin[0], 0);
        chk("t1_lat_early", pndng[9], 0);
        @(negedge clk);
        e    = '0;
        e[9] = 1'b1;
        chk("t1_pndng9", pndng[9], 1);
        chk("t1_only9", pndng, e);
        chk("t1_data9", data_out[9], pa);
        pop[9] = 1'b1;
        @(negedge clk);
        chk("t1_pop_pndng", pndng[9], 0);
        chk("t1_pop_data", data_out[9], 0);
        @(negedge clk);
        pop[9] = 1'b0;
        chk("t1_empty_pop", pndng, 0);

        // broadcast from terminal 5
        pb = pk(8'h3C, 4'hF, 4'hF, 1'b1, 23'h5A5A);
        send(5, pb, "t2");
        @(negedge clk);
        e    = '1;
        e[5] = 1'b0;
        chk("t2_pndng", pndng, e);
        chk("t2_src_data", data_out[5], 0);
        for (int j = 0; j < NT; j++)
            if (j != 5)
                chk($sformatf("t2_data%0d", j), data_out[j], pb);
        pop = e;
        @(negedge clk);
        pop = '0;
        chk("t2_drained", pndng, 0);

        // contention: 0, 4, 12 -> id 9; pointer of egress 9 sits at 1
        ex[0] = pk(8'h02, 4'd5, 4'd2, 1'b1, 23'h104);
        ex[1] = pk(8'h03, 4'd5, 4'd2, 1'b0, 23'h10C);
        ex[2] = pk(8'h01, 4'd5, 4'd2, 1'b0, 23'h100);
        data_out_i_in[4]  = ex[0];
        data_out_i_in[12] = ex[1];
        data_out_i_in[0]  = ex[2];
        pndng_i_in[0]  = 1'b1;
        pndng_i_in[4]  = 1'b1;
        pndng_i_in[12] = 1'b1;
        @(negedge clk);
        chk("t3_popin", {popin[0], popin[4], popin[12]}, 3'b111);
        @(posedge clk);
        @(negedge clk);
        pndng_i_in = '0;
        @(negedge clk);
        e    = '0;
        e[9] = 1'b1;
        chk("t3_first_only9", pndng, e);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t3_order%0d", k), data_out[9], ex[k]);
            pop[9] = 1'b1;
            @(negedge clk);
            pop[9] = 1'b0;
        end
        chk("t3_none_left", pndng, 0);

        // unroutable address is accepted then dropped
        pi = pk(8'h07, 4'd1, 4'd1, 1'b0, 23'h77);
        send(2, pi, "t4");
        repeat (3) @(negedge clk);
        chk("t4_no_pndng", pndng, 0);
        pa = pk(8'h08, 4'd0, 4'd1, 1'b0, 23'h42);
        send(2, pa, "t4b");
        @(negedge clk);
        chk("t4b_pndng0", pndng[0], 1);
        chk("t4b_data0", data_out[0], pa);
        pop[0] = 1'b1;
        @(negedge clk);
        pop[0] = 1'b0;

        // backpressure: 10 packets 0 -> id 3 with no pops
        sent = 0;
        got  = 0;
        acc  = 1'b0;
        pndng_i_in[0]    = 1'b1;
        data_out_i_in[0] = pk(8'h40, 4'd0, 4'd4, 1'b0, 23'd1);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (acc) begin
                sent++;
                data_out_i_in[0] = pk(8'(8'h40 + sent), 4'd0, 4'd4,
                                      1'b0, 23'(sent * 3 + 1));
            end
            acc = popin[0];
        end
        chk("t5_stall_count", sent, 8);
        chk("t5_stall_popin", popin[0], 0);
        chk("t5_pndng3", pndng[3], 1);
        for (int c = 0; c < 80 && got < 10; c++) begin
            @(negedge clk);
            if (acc) begin
                sent++;
                if (sent < 10)
                    data_out_i_in[0] = pk(8'(8'h40 + sent), 4'd0, 4'd4,
                                          1'b0, 23'(sent * 3 + 1));
                else
                    pndng_i_in[0] = 1'b0;
            end
            acc = popin[0];
            if (pndng[3]) begin
                chk($sformatf("t5_data%0d", got), data_out[3],
                    pk(8'(8'h40 + got), 4'd0, 4'd4, 1'b0,
                       23'(got * 3 + 1)));
                got++;
                pop[3] = 1'b1;
            end else begin
                pop[3] = 1'b0;
            end
        end
        @(negedge clk);
        pop[3]        = 1'b0;
        pndng_i_in[0] = 1'b0;
        chk("t5_got", got, 10);
        chk("t5_sent", sent, 10);
        chk("t5_drained", pndng, 0);

        // reset with traffic in flight
        data_out_i_in[0]  = pk(8'h51, 4'd5, 4'd2, 1'b0, 23'h200);
        data_out_i_in[4]  = pk(8'h52, 4'd5, 4'd2, 1'b0, 23'h204);
        data_out_i_in[12] = pk(8'h53, 4'd5, 4'd2, 1'b0, 23'h20C);
        pndng_i_in[0]  = 1'b1;
        pndng_i_in[4]  = 1'b1;
        pndng_i_in[12] = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        pndng_i_in = '0;
        pr = pk(8'h09, 4'd0, 4'd1, 1'b0, 23'h7);
        pndng_i_in[7]    = 1'b1;
        data_out_i_in[7] = pr;
        @(negedge clk);
        chk("t6_inflight", pndng[9], 1);
        chk("t6_popin_live", popin[7], 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_pndng", pndng, 0);
        chk("t6_rst_popin", popin, 0);
        chk("t6_rst_data9", data_out[9], 0);
        repeat (2) @(negedge clk);
        chk("t6_hold_popin", popin[7], 0);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_rel_edge1", popin[7], 0);
        @(negedge clk);
        chk("t6_rel_edge2", popin[7], 1);
        @(posedge clk);
        @(negedge clk);
        pndng_i_in[7] = 1'b0;
        @(negedge clk);
        chk("t6_new_pndng0", pndng[0], 1);
        chk("t6_new_data0", data_out[0], pr);
        pop[0] = 1'b1;
        @(negedge clk);
        pop[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6_no_stale", pndng, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
